snake_motion_ctrl: RTL
======================

# snake_motion_ctrl

Movement and collision stage that feeds the score tracker. It holds the snake body as a position shift buffer and advances it one cell per game tick in the latched direction. Wall, self and apple hits are checked against the next head position, and the stage emits the one-cycle `goodColl`/`badColl` pulses that the score tracker consumes. It takes per-button direction pulses from the edge-detector stage, the apple position from the apple generator, and serves a segment read port to the display renderer.

## Interface
- `GRID_W`, 8: grid columns; legal x is 0..GRID_W-1; must be ≤16.
- `GRID_H`, 8: grid rows; legal y is 0..GRID_H-1, y=0 is the top row; must be ≤16.
- `MAX_LEN`, 50: body buffer depth; length saturates here; must be ≤63.

Ports:
- `clk` in 1: single clock for all state.
- `rst` in 1: synchronous, active-high reset.
- `tick` in 1: one-cycle game-step strobe.
- `direction` in 4: one-cycle press pulses; [3]=up, [2]=down, [1]=left, [0]=right.
- `appleX`, `appleY` in 4 each: current apple cell.
- `rdIdx` in 6: segment index for the renderer; 0 is the head.
- `goodColl` out 1: registered one-cycle pulse; apple eaten.
- `badColl` out 1: registered one-cycle pulse; wall or self hit.
- `headX`, `headY` out 4 each: registered head position.
- `snakeLen` out 6: registered length, 1..MAX_LEN.
- `alive` out 1: high only in RUN.
- `rdX`, `rdY` out 4 each, `rdValid` out 1: combinational read of segment `rdIdx`; `rdValid` = (`rdIdx` < `snakeLen`); X/Y read 0 when not valid.

## Operation
- States:
  - IDLE: after reset, waiting for the first press.
  - RUN: snake moves on every `tick`.
  - DEAD: after `badColl`, body frozen for display.
- Init values: `body[0]` = (1, GRID_H/2), length 1, `curDir` = right, `pendDir` = right.
- A press is valid only if exactly one bit of `direction` is set. Pulses with zero or multiple bits set are ignored.
- IDLE or DEAD, on a valid press:
  - re-apply init values;
  - set `curDir` and `pendDir` to the pressed direction;
  - go to RUN.
  - `tick` is ignored in IDLE and DEAD.
- RUN, on a valid press: `pendDir` takes the press, unless the press is the reverse of `curDir` and length > 1. A rejected press leaves `pendDir` unchanged. If several valid presses arrive between ticks, the last one wins.
- RUN, on `tick`:
  - `curDir` ← `pendDir`.
  - Next head = `body[0]` stepped one cell in `pendDir`: up is y−1, down is y+1, left is x−1, right is x+1.
- Wall hit: the step leaves the grid, either by x/y underflow below 0 or by reaching GRID_W/GRID_H. There is no wrap-around.
- Grow flag = (next head == (appleX, appleY)).
- Self hit: next head equals any `body[i]` with i < length−1, or with i < length when the grow flag is set. The vacating tail is exempt only when the snake is not growing.
- Bad outcome (wall or self hit): pulse `badColl`, do not move the body, go to DEAD. Bad takes priority; `goodColl` is not pulsed on the same step.
- Otherwise:
  - shift the body: `body[i+1]` ← `body[i]`, then `body[0]` ← next head;
  - if grow: pulse `goodColl` and set length ← min(length+1, MAX_LEN). At MAX_LEN the tail still moves and `goodColl` still pulses.
- A valid press in the same cycle as `tick` does not affect that tick's step. It is latched for the next tick, still subject to the reversal check against the new `curDir`.
- Reset values: state IDLE, `goodColl` 0, `badColl` 0, `headX` 1, `headY` GRID_H/2, `snakeLen` 1, `alive` 0, init body and directions.
- Reset mid-operation clears everything on the next edge. Pending presses are lost.

## Timing
- Tick at cycle T: position, length and state update at edge T+1. `goodColl`/`badColl` are high for exactly cycle T+1.
- `alive` rises one cycle after the starting press and falls in the same cycle `badColl` is high.
- Pulses can never repeat on consecutive cycles; the minimum spacing is the tick spacing.
- Read port: `rdX`/`rdY`/`rdValid` reflect the registered body with zero latency.

## Test plan
- Reset, then press right at cycle 5, then 3 ticks with apple at (7,7) → `alive`=1 from cycle 6; head reads (2,4), (3,4), (4,4); no pulses.
- Apple at (2,4), start right, one tick → `goodColl` high one cycle; `snakeLen`=2; `rdIdx`=1 reads (1,4) with `rdValid`=1; `rdIdx`=2 reads `rdValid`=0.
- Length 2 heading right, press left, then tick → press rejected; head moves to x+1. Pressing up then left before the tick → up is used.
- Head at (7,4) heading right, tick → `badColl` for one cycle; `alive`=0; head stays (7,4); later ticks do nothing. A press then re-inits the snake to (1,4) with length 1.
- Length 5 snake turns up, left, down into its own body → `badColl` and no `goodColl`, even with the apple on that cell. Moving into the vacating tail cell with no apple → legal move.
- Assert `rst` during RUN with length 4 → the next cycle shows the reset values. Press and tick in the same cycle → no move that cycle, and the press takes effect on the next tick.

Source files
------------

// File: rtl/snake_motion_ctrl.sv
// Snake movement and collision stage: keeps the body as a position shift buffer,
// steps it on each game tick and reports apple (good) and wall/self (bad) hits.
module snake_motion_ctrl #(
    parameter int GRID_W  = 8,
    parameter int GRID_H  = 8,
    parameter int MAX_LEN = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [3:0] direction,
    input  logic [3:0] appleX,
    input  logic [3:0] appleY,
    input  logic [5:0] rdIdx,
    output logic       goodColl,
    output logic       badColl,
    output logic [3:0] headX,
    output logic [3:0] headY,
    output logic [5:0] snakeLen,
    output logic       alive,
    output logic [3:0] rdX,
    output logic [3:0] rdY,
    output logic       rdValid
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DEAD = 2'd2;

    // Directions are kept one-hot in the same bit order as the press input.
    localparam logic [3:0] DIR_UP    = 4'b1000;
    localparam logic [3:0] DIR_DOWN  = 4'b0100;
    localparam logic [3:0] DIR_LEFT  = 4'b0010;
    localparam logic [3:0] DIR_RIGHT = 4'b0001;

    localparam logic [3:0] X_MAX   = 4'(GRID_W - 1);
    localparam logic [3:0] Y_MAX   = 4'(GRID_H - 1);
    localparam logic [3:0] INIT_X  = 4'd1;
    localparam logic [3:0] INIT_Y  = 4'(GRID_H / 2);
    localparam logic [5:0] LEN_MAX = 6'(MAX_LEN);

    logic [1:0] state_reg;
    logic [3:0] cur_dir_reg;
    logic [3:0] pend_dir_reg;
    logic [5:0] len_reg;
    logic       good_reg;
    logic       bad_reg;
    logic [3:0] body_x_reg [MAX_LEN];
    logic [3:0] body_y_reg [MAX_LEN];

    logic               press_valid;
    logic               start;
    logic               do_step;
    logic [3:0]         next_x;
    logic [3:0]         next_y;
    logic               wall_hit;
    logic               grow;
    logic [5:0]         hit_limit;
    logic [MAX_LEN-1:0] self_vec;
    logic               self_hit;
    logic               bad_step;
    logic               move;
    logic [5:0]         len_next;
    logic [3:0]         eff_dir;
    logic [3:0]         rev_dir;
    logic               press_accept;

    assign press_valid = (direction != 4'd0) && ((direction & (direction - 4'd1)) == 4'd0);
    assign start       = (state_reg != ST_RUN) && press_valid;
    assign do_step     = (state_reg == ST_RUN) && tick;

    always_comb begin
        next_x   = body_x_reg[0];
        next_y   = body_y_reg[0];
        wall_hit = 1'b0;
        case (pend_dir_reg)
            DIR_UP: begin
                next_y   = body_y_reg[0] - 4'd1;
                wall_hit = (body_y_reg[0] == 4'd0);
            end
            DIR_DOWN: begin
                next_y   = body_y_reg[0] + 4'd1;
                wall_hit = (body_y_reg[0] == Y_MAX);
            end
            DIR_LEFT: begin
                next_x   = body_x_reg[0] - 4'd1;
                wall_hit = (body_x_reg[0] == 4'd0);
            end
            default: begin
                next_x   = body_x_reg[0] + 4'd1;
                wall_hit = (body_x_reg[0] == X_MAX);
            end
        endcase
    end

    assign grow = (next_x == appleX) && (next_y == appleY);
    // The tail cell is vacated during a plain move, so it only counts when growing.
    assign hit_limit = grow ? len_reg : (len_reg - 6'd1);

    genvar gi;
    generate
        for (gi = 0; gi < MAX_LEN; gi++) begin : g_self
            assign self_vec[gi] = (body_x_reg[gi] == next_x) && (body_y_reg[gi] == next_y)
                                  && (6'(gi) < hit_limit);
        end
    endgenerate

    assign self_hit = |self_vec;
    assign bad_step = do_step && (wall_hit || self_hit);
    assign move     = do_step && !bad_step;
    assign len_next = (move && grow && (len_reg < LEN_MAX)) ? (len_reg + 6'd1) : len_reg;

    // A press arriving with a tick is judged against the direction that tick commits.
    assign eff_dir      = do_step ? pend_dir_reg : cur_dir_reg;
    assign rev_dir      = {eff_dir[2], eff_dir[3], eff_dir[0], eff_dir[1]};
    assign press_accept = press_valid && !((direction == rev_dir) && (len_next > 6'd1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            cur_dir_reg   <= DIR_RIGHT;
            pend_dir_reg  <= DIR_RIGHT;
            len_reg       <= 6'd1;
            good_reg      <= 1'b0;
            bad_reg       <= 1'b0;
            body_x_reg[0] <= INIT_X;
            body_y_reg[0] <= INIT_Y;
        end else begin
            good_reg <= move && grow;
            bad_reg  <= bad_step;
            if (start) begin
                state_reg     <= ST_RUN;
                cur_dir_reg   <= direction;
                pend_dir_reg  <= direction;
                len_reg       <= 6'd1;
                body_x_reg[0] <= INIT_X;
                body_y_reg[0] <= INIT_Y;
            end else if (state_reg == ST_RUN) begin
                if (bad_step) begin
                    state_reg <= ST_DEAD;
                end
                if (do_step) begin
                    cur_dir_reg <= pend_dir_reg;
                end
                if (press_accept) begin
                    pend_dir_reg <= direction;
                end
                if (move) begin
                    body_x_reg[0] <= next_x;
                    body_y_reg[0] <= next_y;
                end
                len_reg <= len_next;
            end
        end
    end

    generate
        for (gi = 1; gi < MAX_LEN; gi++) begin : g_shift
            always_ff @(posedge clk) begin
                if (rst) begin
                    body_x_reg[gi] <= 4'd0;
                    body_y_reg[gi] <= 4'd0;
                end else if (move) begin
                    body_x_reg[gi] <= body_x_reg[gi-1];
                    body_y_reg[gi] <= body_y_reg[gi-1];
                end
            end
        end
    endgenerate

    assign goodColl = good_reg;
    assign badColl  = bad_reg;
    assign headX    = body_x_reg[0];
    assign headY    = body_y_reg[0];
    assign snakeLen = len_reg;
    assign alive    = (state_reg == ST_RUN);
    assign rdValid  = (rdIdx < len_reg);
    assign rdX      = rdValid ? body_x_reg[rdIdx] : 4'd0;
    assign rdY      = rdValid ? body_y_reg[rdIdx] : 4'd0;

endmodule
